// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-wide data memory.
// Sub-word stores use read-modify-write. Rejected accesses never reach memory.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

    logic [2:0]  r_state;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_lo;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_busy;
    logic        r_done;
    logic        r_fault;
    logic [1:0]  r_fault_cause;
    logic        r_mem_rw;

    logic [2:0]  w_state_nxt;
    logic [1:0]  w_size_nxt;
    logic        w_sext_nxt;
    logic [1:0]  w_lo_nxt;
    logic [15:0] w_wdata_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_fault_nxt;
    logic [1:0]  w_fault_cause_nxt;
    logic        w_mem_rw_nxt;

    logic [1:0]  w_last_off;
    logic [32:0] w_end;
    logic        w_misaligned;
    logic        w_out_of_range;

    // Extract the addressed lane and extend it into a full word.
    function automatic logic [31:0] f_extract(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   res = {{24{sx & b[7]}}, b};
            2'b01:   res = {{16{sx & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the old word with the low store bits.
    function automatic logic [31:0] f_merge(
        input logic [31:0] word,
        input logic [15:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  lo
    );
        logic [31:0] res;
        res = word;
        if (sz == 2'b00) begin
            case (lo)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                default: res[31:24] = wd[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (lo[1]) res[31:16] = wd;
            else       res[15:0]  = wd;
        end
        return res;
    endfunction

    // Request legality, evaluated in 33 bits so a high address cannot wrap.
    assign w_last_off     = (size == 2'b00) ? 2'd0 : ((size == 2'b01) ? 2'd1 : 2'd3);
    assign w_end          = {1'b0, addr} + 33'(w_last_off);
    assign w_out_of_range = (w_end >= 33'(MEM_BYTES));
    assign w_misaligned   = ((size == 2'b01) && addr[0]) ||
                            (size[1] && (addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_size        <= 2'b00;
            r_sext        <= 1'b0;
            r_lo          <= 2'b00;
            r_wdata       <= 16'd0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_rdata       <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;
            r_mem_rw      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_size        <= w_size_nxt;
            r_sext        <= w_sext_nxt;
            r_lo          <= w_lo_nxt;
            r_wdata       <= w_wdata_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_rdata       <= w_rdata_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_cause <= w_fault_cause_nxt;
            r_mem_rw      <= w_mem_rw_nxt;
        end
    end

    // Next state plus next values of all registered outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_size_nxt        = r_size;
        w_sext_nxt        = r_sext;
        w_lo_nxt          = r_lo;
        w_wdata_nxt       = r_wdata;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_rdata_nxt       = r_rdata;
        w_fault_cause_nxt = CAUSE_NONE;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_size_nxt     = size;
                    w_sext_nxt     = sext;
                    w_lo_nxt       = addr[1:0];
                    w_wdata_nxt    = wdata[15:0];
                    w_mem_addr_nxt = {addr[31:2], 2'b00};
                    if (w_misaligned) begin
                        w_state_nxt       = S_ERR;
                        w_fault_cause_nxt = CAUSE_ALIGN;
                    end else if (w_out_of_range) begin
                        w_state_nxt       = S_ERR;
                        w_fault_cause_nxt = CAUSE_RANGE;
                    end else if (!we) begin
                        w_state_nxt = S_RD;
                    end else if (size[1]) begin
                        w_state_nxt     = S_WR;
                        w_mem_wdata_nxt = wdata;
                    end else begin
                        w_state_nxt = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                w_rdata_nxt = f_extract(mem_rdata, r_size, r_lo, r_sext);
                w_state_nxt = S_FIN;
            end
            S_RMW_RD: begin
                w_mem_wdata_nxt = f_merge(mem_rdata, r_wdata, r_size, r_lo);
                w_state_nxt     = S_WR;
            end
            S_WR:    w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_mem_rw_nxt = (w_state_nxt == S_WR);
        w_done_nxt   = (w_state_nxt == S_FIN) || (w_state_nxt == S_ERR);
        w_fault_nxt  = (w_state_nxt == S_ERR);
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;
    assign rdata       = r_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_rw      = r_mem_rw;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses
// compared against a byte-array memory model.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 64;
    localparam int unsigned WORDS     = MEM_BYTES / 4;
    localparam int unsigned WIDX      = $clog2(WORDS);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .size        (size),
        .sext        (sext),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_cause (fault_cause),
        .rdata       (rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rw      (mem_rw),
        .mem_rdata   (mem_rdata)
    );

    // Word memory: combinational read, write on the falling edge.
    logic [31:0] mem [WORDS];
    assign mem_rdata = mem[mem_addr[WIDX+1:2]];
    always @(negedge clk) begin
        if (mem_rw) mem[mem_addr[WIDX+1:2]] <= mem_wdata;
    end

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] exp_rdata;
    int          n_chk;
    int          n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_mem();
        logic [31:0] w;
        for (int i = 0; i < int'(WORDS); i++) begin
            w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            check_eq($sformatf("mem[%0d]", i), mem[i], w);
        end
    endtask

    // One access from IDLE through to the following IDLE cycle.
    task automatic access(input logic a_we, input logic [1:0] a_size, input logic a_sext,
                          input logic [31:0] a_addr, input logic [31:0] a_wdata, input bit noisy);
        int          nbytes;
        int          exp_lat;
        int          exp_wr;
        int          cyc;
        int          n_wr;
        bit          seen;
        logic [1:0]  exp_cause;
        logic [31:0] v;

        nbytes    = (a_size == 2'b00) ? 1 : ((a_size == 2'b01) ? 2 : 4);
        exp_cause = 2'b00;
        if ((a_addr % 32'(nbytes)) != 0)
            exp_cause = 2'b01;
        else if (longint'(a_addr) + longint'(nbytes) > longint'(MEM_BYTES))
            exp_cause = 2'b10;
        if (exp_cause != 2'b00)  exp_lat = 1;
        else if (!a_we)          exp_lat = 2;
        else if (nbytes == 4)    exp_lat = 2;
        else                     exp_lat = 3;
        exp_wr = (a_we && exp_cause == 2'b00) ? 1 : 0;

        if (exp_cause == 2'b00) begin
            if (a_we) begin
                for (int i = 0; i < nbytes; i++)
                    ref_mem[a_addr + 32'(i)] = a_wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nbytes; i++)
                    v = v | (32'(ref_mem[a_addr + 32'(i)]) << (8*i));
                if (a_sext && nbytes < 4 && v[8*nbytes-1])
                    v = v | (32'hFFFF_FFFF << (8*nbytes));
                exp_rdata = v;
            end
        end

        @(negedge clk);
        req = 1'b1; we = a_we; size = a_size; sext = a_sext; addr = a_addr; wdata = a_wdata;
        @(posedge clk);
        #1 req = 1'b0;
        cyc  = 0;
        n_wr = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_rw) n_wr++;
            if (done) begin
                seen = 1'b1;
                req  = 1'b0;
            end else if (noisy) begin
                req   = 1'($urandom_range(0, 1));
                we    = 1'($urandom_range(0, 1));
                size  = 2'($urandom_range(0, 3));
                addr  = $urandom;
                wdata = $urandom;
            end
        end
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("fault", {31'd0, fault}, {31'd0, exp_cause != 2'b00});
        check_eq("cause", {30'd0, fault_cause}, {30'd0, exp_cause});
        check_eq("rdata", rdata, exp_rdata);
        check_eq("wr_cycles", 32'(n_wr), 32'(exp_wr));
        @(negedge clk);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] v;
        int          dones;
        int          wrs;

        n_chk = 0;
        n_err = 0;
        exp_rdata = 32'd0;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < int'(WORDS); i++) begin
            v = $urandom;
            mem[i] = v;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = v[8*b +: 8];
        end

        repeat (2) @(negedge clk);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_cause", {30'd0, fault_cause}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_maddr", mem_addr, 32'd0);
        check_eq("rst_mwdata", mem_wdata, 32'd0);
        check_eq("rst_mrw",   {31'd0, mem_rw}, 32'd0);
        rst_n = 1'b1;

        // Directed scenarios.
        access(1'b1, 2'b10, 1'b0, 32'd8, 32'hA1B2C3D4, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 1'b0);
        check_eq("tp_word_load", rdata, 32'hA1B2C3D4);
        access(1'b1, 2'b00, 1'b0, 32'd9, 32'h00000077, 1'b0);
        check_eq("tp_rmw_word", mem[2], 32'hA1B277D4);
        access(1'b0, 2'b00, 1'b1, 32'd9, 32'd0, 1'b0);
        check_eq("tp_byte9", rdata, 32'h00000077);
        access(1'b0, 2'b00, 1'b1, 32'd11, 32'd0, 1'b0);
        check_eq("tp_byte11_s", rdata, 32'hFFFFFFA1);
        access(1'b0, 2'b00, 1'b0, 32'd11, 32'd0, 1'b0);
        check_eq("tp_byte11_z", rdata, 32'h000000A1);
        access(1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 1'b0);
        check_eq("tp_half10_s", rdata, 32'hFFFFA1B2);
        access(1'b0, 2'b01, 1'b1, 32'd5, 32'd0, 1'b0);
        check_eq("tp_misalign_hold", rdata, 32'hFFFFA1B2);
        access(1'b0, 2'b10, 1'b0, MEM_BYTES - 2, 32'd0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0);
        access(1'b0, 2'b11, 1'b0, MEM_BYTES - 4, 32'd0, 1'b0);
        check_mem();

        // Reset asserted while a byte store is in its write cycle.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'd13; wdata = 32'h00000055;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 check_eq("pre_rst_mrw", {31'd0, mem_rw}, 32'd1);
        rst_n = 1'b0;
        #1 check_eq("rst_wr_mrw", {31'd0, mem_rw}, 32'd0);
        check_eq("rst_wr_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        exp_rdata = 32'd0;
        check_eq("rst_wr_rdata", rdata, 32'd0);
        check_mem();
        access(1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 1'b0);

        // req held high: one access per IDLE acceptance.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'd8; wdata = 32'd0;
        dones = 0;
        wrs   = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (mem_rw) wrs++;
        end
        req = 1'b0;
        check_eq("held_dones", 32'(dones), 32'd3);
        check_eq("held_writes", 32'(wrs), 32'd0);
        exp_rdata = {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]};
        check_eq("held_rdata", rdata, exp_rdata);
        @(negedge clk);
        check_eq("held_idle", {31'd0, busy}, 32'd0);

        // Randomized accesses.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int          r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = MEM_BYTES - 32'($urandom_range(0, 4));
            else             a = 32'($urandom_range(0, MEM_BYTES - 1));
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, 1'($urandom_range(0, 1)));
            if ((n % 50) == 49) check_mem();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
